dump_reader: RTL and testbench

- Read side of the capture buffer: after a capture completes, walks the circular sample RAM from oldest to newest sample and streams each byte to the UART transmitter.
- Sits between the capture RAM read port, the capture control flags (capture_done) and the UART TX byte handshake.
- Issues one byte per TX handshake.
- Pulses dump_finished and clears capture_done when the last byte is acknowledged.

---
 rtl/dump_reader.sv | 148 ++++++++++++++
 tb/tb_dump_reader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : dump_reader
// Summary  : Streams the circular capture RAM, oldest sample first, to UART TX.
//            Optional sync-byte header when DUMP_HEADER_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module dump_reader #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_dump,
    input  logic              capture_done,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_en,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_done,
    output logic              busy,
    output logic              dump_finished,
    output logic              clr_capture_done
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [DATA_W-1:0] SYNC     = DATA_W'(8'hA5);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RDWAIT  = 3'd2,
        ST_SEND    = 3'd3,
        ST_TXWAIT  = 3'd4,
        ST_DONE    = 3'd5,
        ST_HDR     = 3'd6,
        ST_HDRWAIT = 3'd7
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_cnt;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic                r_ram_en;
    logic [DATA_W-1:0]   r_tx_data;
    logic                r_tx_start;
    logic                r_busy;
    logic                r_fin;
    logic                r_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_ram_addr <= '0;
            r_ram_en   <= 1'b0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_fin      <= 1'b0;
            r_clr      <= 1'b0;
        end else begin
            // Strobes default low so each one lasts exactly one cycle.
            r_ram_en   <= 1'b0;
            r_tx_start <= 1'b0;
            r_fin      <= 1'b0;
            r_clr      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_dump && capture_done) begin
                        r_rd_ptr <= last_addr + 1'b1;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
`ifdef DUMP_HEADER_EN
                        r_tx_data  <= SYNC;
                        r_tx_start <= 1'b1;
                        r_state    <= ST_HDR;
`else
                        r_ram_en   <= 1'b1;
                        r_ram_addr <= last_addr + 1'b1;
                        r_state    <= ST_RD;
`endif
                    end
                end
                ST_RD: begin
                    r_state <= ST_RDWAIT;
                end
                ST_RDWAIT: begin
                    r_tx_data  <= ram_rdata;
                    r_tx_start <= 1'b1;
                    r_state    <= ST_SEND;
                end
                ST_SEND: begin
                    r_state <= ST_TXWAIT;
                end
                ST_TXWAIT: begin
                    if (tx_done) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                        r_cnt    <= r_cnt + 1'b1;
                        if (r_cnt == LAST_CNT) begin
                            r_busy  <= 1'b0;
                            r_fin   <= 1'b1;
                            r_clr   <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_ram_en   <= 1'b1;
                            r_ram_addr <= r_rd_ptr + 1'b1;
                            r_state    <= ST_RD;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
`ifdef DUMP_HEADER_EN
                ST_HDR: begin
                    r_state <= ST_HDRWAIT;
                end
                ST_HDRWAIT: begin
                    // Header leaves rd_ptr and the counter untouched.
                    if (tx_done) begin
                        r_ram_en   <= 1'b1;
                        r_ram_addr <= r_rd_ptr;
                        r_state    <= ST_RD;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ram_addr         = r_ram_addr;
    assign ram_en           = r_ram_en;
    assign tx_data          = r_tx_data;
    assign tx_start         = r_tx_start;
    assign busy             = r_busy;
    assign dump_finished    = r_fin;
    assign clr_capture_done = r_clr;

endmodule
`default_nettype wire

// File: tb/tb_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_dump_reader
// Summary  : Directed self-checking bench for dump_reader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dump_reader;

`ifdef DUMP_HEADER_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif
    localparam int N_BYTES   = HDR ? 513 : 512;
    localparam int FIRST_LAT = HDR ? 1 : 3;

    logic       clk;
    logic       rst_n;
    logic       start_dump;
    logic       capture_done;
    logic [8:0] last_addr;
    logic [8:0] ram_addr;
    logic       ram_en;
    logic [7:0] ram_rdata;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done;
    logic       busy;
    logic       dump_finished;
    logic       clr_capture_done;

    logic [7:0] mem [512];

    int n_total = 0;
    int n_bad   = 0;
    int ack_delay = 4;
    int spur_req  = 0;
    int spur_done = 0;

    // Monitor state
    int         byte_cnt = 0;
    int         ren_cnt  = 0;
    int         seq_err  = 0;
    int         pulse_err = 0;
    int         fin_cnt  = 0;
    logic [8:0] exp_ptr;
    logic [8:0] first_ra;
    logic [8:0] last_ra;
    logic [7:0] cur_byte;
    logic [7:0] exp_b;
    bit         first_seen;
    bit         hdr_pend;
    logic       busy_q = 1'b0;

    dump_reader #(.ADDR_W(9), .DATA_W(8)) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_dump       (start_dump),
        .capture_done     (capture_done),
        .last_addr        (last_addr),
        .ram_addr         (ram_addr),
        .ram_en           (ram_en),
        .ram_rdata        (ram_rdata),
        .tx_data          (tx_data),
        .tx_start         (tx_start),
        .tx_done          (tx_done),
        .busy             (busy),
        .dump_finished    (dump_finished),
        .clr_capture_done (clr_capture_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'(i);
    end

    always @(posedge clk) begin
        if (ram_en) ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // UART TX responder
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                repeat (ack_delay) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end else if (spur_req != spur_done) begin
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
                spur_done++;
            end
        end
    end

    // Stream monitor / reference model
    initial begin
        forever begin
            @(negedge clk);
            if (busy === 1'b1 && busy_q !== 1'b1) begin
                byte_cnt   = 0;
                ren_cnt    = 0;
                seq_err    = 0;
                pulse_err  = 0;
                exp_ptr    = last_addr + 9'd1;
                hdr_pend   = HDR;
                first_seen = 1'b0;
            end
            busy_q = busy;
            if (ram_en === 1'b1) begin
                if (!first_seen) first_ra = ram_addr;
                first_seen = 1'b1;
                last_ra = ram_addr;
                ren_cnt++;
            end
            if (tx_start === 1'b1) begin
                if (hdr_pend) begin
                    exp_b = 8'hA5;
                end else begin
                    exp_b   = mem[exp_ptr];
                    exp_ptr = exp_ptr + 9'd1;
                end
                hdr_pend = 1'b0;
                if (tx_data !== exp_b) seq_err++;
                cur_byte = exp_b;
                byte_cnt++;
            end
            if (tx_done && busy === 1'b1 && tx_data !== cur_byte) seq_err++;
            if (dump_finished === 1'b1) fin_cnt++;
            if (dump_finished !== clr_capture_done || (dump_finished === 1'b1 && busy !== 1'b0))
                pulse_err++;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start_dump = 1'b1;
        @(negedge clk);
        start_dump = 1'b0;
    endtask

    task automatic run_dump(input logic [8:0] la, input bit extra, input bit hold);
        int         lat;
        int         f0;
        int         b0;
        int         r0;
        logic [8:0] nx;
        logic [7:0] fb;
        nx = la + 9'd1;
        fb = HDR ? 8'hA5 : nx[7:0];
        last_addr = la;
        f0 = fin_cnt;
        if (hold) ack_delay = 100;
        @(negedge clk);
        start_dump = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) start_dump = 1'b0;
            if (tx_start) begin
                lat = k;
                break;
            end
        end
        chk("latency", lat, FIRST_LAT);
        chk("first_data", tx_data, fb);
        if (hold) begin
            b0 = byte_cnt;
            r0 = ren_cnt;
            repeat (90) @(negedge clk);
            chk("hold_no_tx_start", byte_cnt, b0);
            chk("hold_no_ram_en", ren_cnt, r0);
            chk("hold_data", tx_data, fb);
            ack_delay = 4;
        end
        if (extra) begin
            repeat (30) @(negedge clk);
            capture_done = 1'b0;
            pulse_start();
            repeat (200) @(negedge clk);
            pulse_start();
        end
        for (int c = 0; c < 20000 && fin_cnt == f0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        capture_done = 1'b1;
        chk("byte_count", byte_cnt, N_BYTES);
        chk("ram_en_count", ren_cnt, 512);
        chk("data_seq_errs", seq_err, 0);
        chk("first_ram_addr", first_ra, nx);
        chk("last_ram_addr", last_ra, la);
        chk("finished_pulses", fin_cnt - f0, 1);
        chk("fin_clr_pulse_errs", pulse_err, 0);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        int act;
        int f0;
        rst_n        = 1'b0;
        start_dump   = 1'b0;
        capture_done = 1'b0;
        last_addr    = 9'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_fin_clr", {dump_finished, clr_capture_done}, 0);

        // Start without a completed capture is ignored
        last_addr = 9'd99;
        pulse_start();
        act = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy || ram_en || tx_start) act++;
        end
        chk("gate_no_capture", act, 0);

        // Spurious tx_done while idle
        capture_done = 1'b1;
        spur_req++;
        act = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || ram_en || tx_start) act++;
        end
        chk("spurious_tx_done", act, 0);

        run_dump(9'd99,  1'b0, 1'b0);
        run_dump(9'd511, 1'b0, 1'b0);
        run_dump(9'd0,   1'b0, 1'b0);
        run_dump(9'd200, 1'b1, 1'b0);
        run_dump(9'd45,  1'b0, 1'b1);

        // Asynchronous reset in the middle of a dump
        f0 = fin_cnt;
        last_addr = 9'd300;
        pulse_start();
        for (int c = 0; c < 2000 && byte_cnt < 37; c++) @(negedge clk);
        chk("bytes_before_reset", byte_cnt, 37);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            {busy, ram_en, tx_start, dump_finished, clr_capture_done, ram_addr, tx_data}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_finish_on_reset", fin_cnt - f0, 0);
        chk("idle_after_reset", busy, 0);
        run_dump(9'd300, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
